dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter that shares the CPU's single-port data memory between the core's load/store path (LDR/STR) and a debug/loader port. It sits between `cpu_top`'s memory-access signals and the data memory instance. Requests are arbitrated round-robin, and each grant performs exactly one access. A debug lock can freeze core access while memory is inspected or preloaded. A saturating counter reports how many cycles the core spent stalled.

## Interface
Parameters:
- DATA_W, 4, memory word width
- ADDR_W, 4, memory address width (16 words)
- STALL_W, 8, width of the stall counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset
- cpu_req  in  1  core requests one access; held with attributes until granted
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  core access address
- cpu_wdata  in  DATA_W  core write data
- cpu_gnt  out  1  core access performed this cycle
- cpu_rvalid  out  1  core read data valid (one-cycle pulse)
- cpu_rdata  out  DATA_W  core read data
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug port; same semantics as the core port
- dbg_gnt, dbg_rvalid, dbg_rdata  out  1/1/DATA_W  debug port; same semantics as the core port
- dbg_lock  in  1  while high, the core is never granted
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, combinational from mem_addr
- cpu_stall_cnt  out  STALL_W  cycles in which the core request was waiting

## Operation
- **Registered grant state:** `owner` ∈ {NONE, CPU, DBG}; `last` ∈ {CPU, DBG}.
- **Eligibility:** computed at each edge.
  - core eligible = `cpu_req & ~cpu_gnt & ~dbg_lock`
  - debug eligible = `dbg_req & ~dbg_gnt`
  - A requester whose grant is active in the current cycle is ineligible for the next cycle.
  - A `req` still high after its grant cycle is treated as a new request.
- **Next owner:**
  - Neither eligible → NONE.
  - One eligible → that one.
  - Both eligible → the one that is not `last`.
  - `last` updates to the owner whenever owner ≠ NONE.
- **Grant outputs:** `cpu_gnt = (owner == CPU)`, `dbg_gnt = (owner == DBG)`. The grants are one-hot or zero.
- **Memory drive:**
  - `mem_addr` / `mem_wdata` come from the owner's inputs.
  - `mem_we = owner_we` when owner ≠ NONE; otherwise `mem_we = 0`, `mem_addr = 0`, `mem_wdata = 0`.
- **Reads:**
  - On a read grant, `mem_rdata` is captured at the end of the grant cycle.
  - `x_rvalid` is driven high for the next cycle only.
  - `x_rdata` holds its value until the next read completes for that port.
- **Writes:** no `rvalid` is generated.
- **Stall counter:** `cpu_stall_cnt` increments every edge where `cpu_req = 1` and `cpu_gnt = 0`, including cycles spent locked. It saturates at all-ones and is cleared only by reset.
- **dbg_lock:**
  - Asserting it does not abort a core grant already active this cycle.
  - Deasserting it makes the core eligible at the next edge.

## Timing
- **Reset values:** `reset = 0` at an edge → owner = NONE, last = DBG, so the core wins the first tie. All gnt/rvalid = 0, rdata = 0, mem_* = 0, cpu_stall_cnt = 0. Reset overrides any in-flight read, which is lost.
- **Latency:** `req` high before edge E → gnt high in cycle E..E+1 (if chosen) → write committed / read sampled at edge E+1 → rvalid high in cycle E+1..E+2.
- **Throughput:**
  - Single requester holding req continuously: grant every other cycle (50%).
  - Two contending requesters: strict alternation, memory busy every cycle.
- **Simultaneous requests with equal eligibility:** the result depends only on `last`.
- **Requester obligations:** keep addr/we/wdata stable from req assertion through the grant cycle. Dropping req before grant withdraws the request with no side effect.
- **Stall-counter example:** one cycle of contention loss = +1 to cpu_stall_cnt; an uncontended first request costs +1, because the counter counts the arbitration cycle.

## Test plan
- **Reset:** hold reset low 2 cycles with both reqs high → all outputs 0 and cpu_stall_cnt = 0. First edge after release: cpu_gnt = 1, dbg_gnt = 0.
- **Core write/read:**
  - Core write addr 3, data 9 → mem_we = 1, mem_addr = 3, mem_wdata = 9 during cpu_gnt.
  - Then core read addr 3 → cpu_rvalid one cycle after the grant, cpu_rdata = 9.
- **Contention:** both reqs held high for 8 cycles → grants alternate CPU, DBG, CPU, DBG…; never both high; cpu_stall_cnt increments on every non-grant cycle.
- **Lock:**
  - dbg_lock = 1, core req high for 5 cycles, debug idle → cpu_gnt stays 0 and cpu_stall_cnt = 5.
  - Release the lock → cpu_gnt at the next edge.
- **Saturation:** STALL_W = 3, lock held with core req high for 12 cycles → cpu_stall_cnt stops at 7.
- **Reset mid-read:** debug read granted, reset asserted at the grant edge → dbg_rvalid never pulses and dbg_rdata = 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin share of one data memory between the core load/store port and a debug/loader port
//   clk, reset (sync, active-low)
//   cpu_* : core request/attributes in; gnt, rvalid, rdata out
//   dbg_* : debug request/attributes in; gnt, rvalid, rdata out
//   dbg_lock : blocks new core grants while high
//   mem_* : memory drive out, mem_rdata combinational back in
//   cpu_stall_cnt : saturating count of cycles the core request waited
module dmem_arbiter #(
  parameter int DATA_W  = 4,
  parameter int ADDR_W  = 4,
  parameter int STALL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  output logic               cpu_gnt,
  output logic               cpu_rvalid,
  output logic [DATA_W-1:0]  cpu_rdata,
  input  logic               dbg_req,
  input  logic               dbg_we,
  input  logic [ADDR_W-1:0]  dbg_addr,
  input  logic [DATA_W-1:0]  dbg_wdata,
  output logic               dbg_gnt,
  output logic               dbg_rvalid,
  output logic [DATA_W-1:0]  dbg_rdata,
  input  logic               dbg_lock,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic [STALL_W-1:0] cpu_stall_cnt
);
  typedef enum logic [1:0] {NONE, CPU, DBG} owner_t;
  owner_t r_owner, r_last, w_next;
  logic w_cpu_el, w_dbg_el;
  // a port granted this cycle sits out the next arbitration, giving 50% max per port
  assign w_cpu_el = cpu_req & ~cpu_gnt & ~dbg_lock;
  assign w_dbg_el = dbg_req & ~dbg_gnt;
  assign cpu_gnt  = (r_owner == CPU);
  assign dbg_gnt  = (r_owner == DBG);
  always_comb begin
    w_next    = (w_cpu_el & w_dbg_el) ? ((r_last == DBG) ? CPU : DBG) :
                w_cpu_el ? CPU : w_dbg_el ? DBG : NONE;
    mem_we    = cpu_gnt ? cpu_we    : dbg_gnt ? dbg_we    : 1'b0;
    mem_addr  = cpu_gnt ? cpu_addr  : dbg_gnt ? dbg_addr  : '0;
    mem_wdata = cpu_gnt ? cpu_wdata : dbg_gnt ? dbg_wdata : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_owner       <= NONE;
      r_last        <= DBG;
      cpu_rvalid    <= 1'b0;
      dbg_rvalid    <= 1'b0;
      cpu_rdata     <= '0;
      dbg_rdata     <= '0;
      cpu_stall_cnt <= '0;
    end else begin
      r_owner    <= w_next;
      if (w_next != NONE) r_last <= w_next;
      cpu_rvalid <= cpu_gnt & ~cpu_we;
      dbg_rvalid <= dbg_gnt & ~dbg_we;
      if (cpu_gnt & ~cpu_we) cpu_rdata <= mem_rdata;
      if (dbg_gnt & ~dbg_we) dbg_rdata <= mem_rdata;
      if (cpu_req & ~cpu_gnt & ~&cpu_stall_cnt) cpu_stall_cnt <= cpu_stall_cnt + STALL_W'(1);
    end
  end
endmodule
